// File: rtl/sm3_pkg.sv
// Shared SM3 constants, widths and arbiter FSM state encodings.
package sm3_pkg;

    localparam int SM3_BLK_W  = 512;
    localparam int SM3_HASH_W = 256;

    localparam logic [SM3_HASH_W-1:0] SM3_IV =
        256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;

    typedef logic [SM3_BLK_W-1:0]  sm3_blk_t;
    typedef logic [SM3_HASH_W-1:0] sm3_hash_t;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_GRANT  = 3'd1;
    localparam logic [2:0] ST_ISSUE  = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_UPDATE = 3'd4;
    localparam logic [2:0] ST_OUT    = 3'd5;

endpackage

// File: rtl/sm3_ctx_arbiter_if.sv
// Bundle of requester, compression-core and digest-output signals of the arbiter.
interface sm3_ctx_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    import sm3_pkg::*;

    logic [NREQ-1:0]           req_valid;
    logic [NREQ-1:0]           req_ready;
    logic [NREQ*SM3_BLK_W-1:0] req_data;
    logic [NREQ-1:0]           req_first;
    logic [NREQ-1:0]           req_last;

    sm3_blk_t                  core_datain;
    sm3_hash_t                 core_hashin;
    logic                      core_start;
    sm3_hash_t                 core_hashout;
    logic                      core_valid;

    logic                      dout_valid;
    logic                      dout_ready;
    logic [IDW-1:0]            dout_id;
    sm3_hash_t                 dout_hash;

    // master = arbiter side, slave = requesters, core and digest consumer
    modport master (
        input  req_valid, req_data, req_first, req_last,
        output req_ready,
        output core_datain, core_hashin, core_start,
        input  core_hashout, core_valid,
        output dout_valid, dout_id, dout_hash,
        input  dout_ready
    );

    modport slave (
        output req_valid, req_data, req_first, req_last,
        input  req_ready,
        input  core_datain, core_hashin, core_start,
        output core_hashout, core_valid,
        input  dout_valid, dout_id, dout_hash,
        output dout_ready
    );

endinterface

// File: rtl/sm3_rr_pick.sv
// Combinational round-robin picker: first requesting index at or after ptr_i, wrapping.
module sm3_rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [IDW-1:0]  idx_o,
    output logic            any_o
);

    logic [IDW-1:0] cand;

    // Scan farthest-first so the nearest requester after the pointer wins.
    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = IDW'((int'(ptr_i) + k) % NREQ);
            if (req_i[cand]) begin
                idx_o = cand;
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sm3_ctx_arbiter.sv
// Shares one SM3 compression core among NREQ channels, keeping a chaining value per channel
// so messages interleave block-by-block; final digests leave on one tagged output port.
module sm3_ctx_arbiter
    import sm3_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic               clk,
    input  logic               rstn,
    sm3_ctx_arbiter_if.master  bus,
    output logic               busy
);

    logic [2:0]      state_q, state_d;
    logic [IDW-1:0]  rr_q;
    logic [IDW-1:0]  gid_q;
    logic            first_q;
    logic            last_q;
    sm3_blk_t        blk_q;
    sm3_hash_t       res_q;
    sm3_hash_t       chain_q [NREQ];

    logic            core_start_q;
    sm3_blk_t        core_datain_q;
    sm3_hash_t       core_hashin_q;
    logic            dout_valid_q;
    logic [IDW-1:0]  dout_id_q;
    sm3_hash_t       dout_hash_q;

    logic [IDW-1:0]  pick_idx;
    logic            pick_any;
    sm3_blk_t        req_blk [NREQ];

    for (genvar k = 0; k < NREQ; k++) begin : g_unpack
        assign req_blk[k] = bus.req_data[k*SM3_BLK_W +: SM3_BLK_W];
    end

    sm3_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req_i (bus.req_valid),
        .ptr_i (rr_q),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (|bus.req_valid) state_d = ST_GRANT;
            ST_GRANT:  state_d = pick_any ? ST_ISSUE : ST_IDLE;
            ST_ISSUE:  state_d = ST_WAIT;
            ST_WAIT:   if (bus.core_valid) state_d = ST_UPDATE;
            ST_UPDATE: state_d = last_q ? ST_OUT : ST_IDLE;
            ST_OUT:    if (bus.dout_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // A requester that dropped valid before GRANT simply gets no accept pulse.
    always_comb begin
        bus.req_ready = '0;
        if (state_q == ST_GRANT && pick_any) bus.req_ready[pick_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= ST_IDLE;
            rr_q          <= '0;
            gid_q         <= '0;
            first_q       <= 1'b0;
            last_q        <= 1'b0;
            core_start_q  <= 1'b0;
            core_datain_q <= '0;
            core_hashin_q <= '0;
            dout_valid_q  <= 1'b0;
            dout_id_q     <= '0;
            dout_hash_q   <= '0;
            for (int k = 0; k < NREQ; k++) chain_q[k] <= SM3_IV;
        end else begin
            state_q      <= state_d;
            core_start_q <= (state_q == ST_ISSUE);
            case (state_q)
                ST_GRANT: if (pick_any) begin
                    gid_q   <= pick_idx;
                    first_q <= bus.req_first[pick_idx];
                    last_q  <= bus.req_last[pick_idx];
                    rr_q    <= (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + IDW'(1);
                end
                // A first block ignores whatever partial chain the channel still holds.
                ST_ISSUE: begin
                    core_hashin_q <= first_q ? SM3_IV : chain_q[gid_q];
                    core_datain_q <= blk_q;
                end
                ST_UPDATE: begin
                    chain_q[gid_q] <= last_q ? SM3_IV : res_q;
                    if (last_q) begin
                        dout_hash_q  <= res_q;
                        dout_id_q    <= gid_q;
                        dout_valid_q <= 1'b1;
                    end
                end
                ST_OUT: if (bus.dout_ready) dout_valid_q <= 1'b0;
                default: ;
            endcase
        end
    end

    // Wide datapath holding registers; only ever consumed after the control path loads them.
    always_ff @(posedge clk) begin
        if (state_q == ST_GRANT && pick_any) blk_q <= req_blk[pick_idx];
        if (state_q == ST_WAIT && bus.core_valid) res_q <= bus.core_hashout;
    end

    assign bus.core_start  = core_start_q;
    assign bus.core_datain = core_datain_q;
    assign bus.core_hashin = core_hashin_q;
    assign bus.dout_valid  = dout_valid_q;
    assign bus.dout_id     = dout_id_q;
    assign bus.dout_hash   = dout_hash_q;
    assign busy            = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sm3_ctx_arbiter.sv
// Scoreboard bench for sm3_ctx_arbiter with a behavioural SM3 compression core.
module tb_sm3_ctx_arbiter;

    localparam int NREQ     = 4;
    localparam int IDW      = 2;
    localparam int CORE_LAT = 3;

    localparam logic [255:0] DIG_ABC  =
        256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0;
    localparam logic [255:0] DIG_ABCD =
        256'hdebe9ff9_2275b8a1_38604889_c18e5a4d_6fdb70e5_387e5765_293dcba3_9c0c5732;
    localparam logic [511:0] BLK_ABC = {32'h61626380, 416'h0, 64'h18};
    localparam logic [511:0] BLK_D1  = {16{32'h61626364}};
    localparam logic [511:0] BLK_D2  = {32'h80000000, 416'h0, 64'h200};

    typedef struct packed { logic [511:0] data; logic first; logic last; } blk_t;
    typedef struct packed { logic [IDW-1:0] id; logic [255:0] hash; } dig_t;

    logic clk = 1'b0;
    logic rstn;
    logic busy;

    always #5 clk = ~clk;

    sm3_ctx_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) ifc ();

    sm3_ctx_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (ifc.master),
        .busy (busy)
    );

    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_starts = 0;
    int   spur_req = 0;
    blk_t chq [NREQ][$];
    dig_t exp_dig [$];
    int   exp_gnt [$];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    task automatic note_fail(input string name);
        n_chk++;
        $display("FAIL %s: event not observed as required", name);
    endtask

    function automatic logic [31:0] rol(input logic [31:0] x, input int n);
        return (n == 0) ? x : ((x << n) | (x >> (32 - n)));
    endfunction

    function automatic logic [31:0] p0(input logic [31:0] x);
        return x ^ rol(x, 9) ^ rol(x, 17);
    endfunction

    function automatic logic [31:0] p1(input logic [31:0] x);
        return x ^ rol(x, 15) ^ rol(x, 23);
    endfunction

    function automatic logic [255:0] sm3_cf(input logic [255:0] v, input logic [511:0] blk);
        logic [31:0] w [68];
        logic [31:0] w1 [64];
        logic [31:0] a, b, c, d, e, f, g, h, ss1, ss2, tt1, tt2, tj, ff, gg;
        for (int j = 0; j < 16; j++) w[j] = blk[511 - 32*j -: 32];
        for (int j = 16; j < 68; j++)
            w[j] = p1(w[j-16] ^ w[j-9] ^ rol(w[j-3], 15)) ^ rol(w[j-13], 7) ^ w[j-6];
        for (int j = 0; j < 64; j++) w1[j] = w[j] ^ w[j+4];
        {a, b, c, d, e, f, g, h} = v;
        for (int j = 0; j < 64; j++) begin
            tj  = (j < 16) ? 32'h79cc4519 : 32'h7a879d8a;
            ss1 = rol(rol(a, 12) + e + rol(tj, j % 32), 7);
            ss2 = ss1 ^ rol(a, 12);
            ff  = (j < 16) ? (a ^ b ^ c) : ((a & b) | (a & c) | (b & c));
            gg  = (j < 16) ? (e ^ f ^ g) : ((e & f) | (~e & g));
            tt1 = ff + d + ss2 + w1[j];
            tt2 = gg + h + ss1 + w[j];
            d = c; c = rol(b, 9); b = a; a = tt1;
            h = g; g = rol(f, 19); f = e; e = p0(tt2);
        end
        return v ^ {a, b, c, d, e, f, g, h};
    endfunction

    task automatic push_blk(input int ch, input logic [511:0] d, input logic f, input logic l);
        blk_t x;
        x.data = d; x.first = f; x.last = l;
        chq[ch].push_back(x);
    endtask

    task automatic push_dig(input int id, input logic [255:0] h);
        dig_t x;
        x.id = IDW'(id); x.hash = h;
        exp_dig.push_back(x);
    endtask

    function automatic bit all_idle();
        bit e;
        e = (exp_dig.size() == 0) && (exp_gnt.size() == 0) && !busy;
        for (int k = 0; k < NREQ; k++) if (chq[k].size() != 0) e = 1'b0;
        return e;
    endfunction

    task automatic wait_done(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            done = all_idle();
        end
        if (!done) note_fail(name);
    endtask

    // Requester driver: handshake sampled mid-cycle, next block presented after the edge.
    initial begin
        logic [NREQ-1:0]      hs, v, f, l;
        logic [NREQ*512-1:0]  d;
        blk_t                 cur;
        ifc.req_valid = '0; ifc.req_data = '0; ifc.req_first = '0; ifc.req_last = '0;
        forever begin
            @(negedge clk);
            hs = ifc.req_valid & ifc.req_ready;
            @(posedge clk);
            #1;
            v = '0; f = '0; l = '0; d = ifc.req_data;
            for (int ch = 0; ch < NREQ; ch++) begin
                if (hs[ch] && chq[ch].size() > 0) void'(chq[ch].pop_front());
                if (chq[ch].size() > 0) begin
                    cur = chq[ch][0];
                    v[ch] = 1'b1; f[ch] = cur.first; l[ch] = cur.last;
                    d[ch*512 +: 512] = cur.data;
                end
            end
            ifc.req_valid = v; ifc.req_first = f; ifc.req_last = l; ifc.req_data = d;
        end
    end

    // Behavioural compression core; drops its in-flight result on reset.
    initial begin
        logic [255:0] res;
        bit           pend;
        int           cnt;
        int           spur_done;
        pend = 1'b0; cnt = 0; spur_done = 0; res = '0;
        ifc.core_valid = 1'b0; ifc.core_hashout = '0;
        forever begin
            @(negedge clk);
            ifc.core_valid = 1'b0;
            if (!rstn) pend = 1'b0;
            else begin
                if (pend) begin
                    if (cnt == 0) begin
                        ifc.core_hashout = res; ifc.core_valid = 1'b1; pend = 1'b0;
                    end else cnt--;
                end else if (spur_done != spur_req) begin
                    spur_done = spur_req;
                    ifc.core_hashout = {8{32'hdeadbeef}}; ifc.core_valid = 1'b1;
                end
                if (ifc.core_start) begin
                    if (pend) note_fail("core_overlap");
                    res  = sm3_cf(ifc.core_hashin, ifc.core_datain);
                    pend = 1'b1; cnt = CORE_LAT; n_starts++;
                end
            end
        end
    end

    // Monitor: grants, grant-to-start latency, and digests against the scoreboard.
    initial begin
        int   g, e, due;
        dig_t x;
        due = 0;
        forever begin
            @(negedge clk);
            if (due > 0) begin
                due--;
                if (due == 0) chk("start_latency", 256'(ifc.core_start), 256'd1);
            end
            if (rstn && ifc.req_ready != '0) begin
                chk("ready_onehot", 256'($onehot(ifc.req_ready) && ((ifc.req_ready & ~ifc.req_valid) == '0)), 256'd1);
                g = 0;
                for (int k = 0; k < NREQ; k++) if (ifc.req_ready[k]) g = k;
                if (exp_gnt.size() == 0) note_fail("unexpected_grant");
                else begin
                    e = exp_gnt.pop_front();
                    chk("grant_id", 256'(g), 256'(e));
                end
                due = 2;
            end
            if (ifc.dout_valid && ifc.dout_ready) begin
                if (exp_dig.size() == 0) note_fail("unexpected_dout");
                else begin
                    x = exp_dig.pop_front();
                    chk("dout_id", 256'(ifc.dout_id), 256'(x.id));
                    chk("dout_hash", ifc.dout_hash, x.hash);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int  s0;
        bit  seen;
        rstn = 1'b0;
        ifc.dout_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_dout_valid", 256'(ifc.dout_valid), 256'd0);
        chk("rst_dout_hash", ifc.dout_hash, 256'd0);
        chk("rst_core_start", 256'(ifc.core_start), 256'd0);
        chk("rst_core_hashin", ifc.core_hashin, 256'd0);
        chk("rst_busy", 256'(busy), 256'd0);
        rstn = 1'b1;

        // single-block "abc" on ch0
        exp_gnt.push_back(0); push_dig(0, DIG_ABC);
        push_blk(0, BLK_ABC, 1'b1, 1'b1);
        wait_done("t1_abc");

        // ch1 and ch3 interleave two-block messages
        exp_gnt.push_back(1); exp_gnt.push_back(3); exp_gnt.push_back(1); exp_gnt.push_back(3);
        push_dig(1, DIG_ABCD); push_dig(3, DIG_ABCD);
        push_blk(1, BLK_D1, 1'b1, 1'b0); push_blk(1, BLK_D2, 1'b0, 1'b1);
        push_blk(3, BLK_D1, 1'b1, 1'b0); push_blk(3, BLK_D2, 1'b0, 1'b1);
        wait_done("t3_interleave");

        // two-block message on ch2
        exp_gnt.push_back(2); exp_gnt.push_back(2); push_dig(2, DIG_ABCD);
        push_blk(2, BLK_D1, 1'b1, 1'b0); push_blk(2, BLK_D2, 1'b0, 1'b1);
        wait_done("t2_two_block");

        // restart mid-message: stale chain must be discarded
        exp_gnt.push_back(0); exp_gnt.push_back(0); push_dig(0, DIG_ABC);
        push_blk(0, BLK_D1, 1'b1, 1'b0); push_blk(0, BLK_ABC, 1'b1, 1'b1);
        wait_done("t4_restart");

        // back-pressure on the digest port with ch1 waiting
        ifc.dout_ready = 1'b0;
        exp_gnt.push_back(0); push_dig(0, DIG_ABC);
        push_blk(0, BLK_ABC, 1'b1, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = ifc.dout_valid;
        end
        if (!seen) note_fail("t5_dout_valid");
        exp_gnt.push_back(1); push_dig(1, DIG_ABC);
        push_blk(1, BLK_ABC, 1'b1, 1'b1);
        s0 = n_starts;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 5) spur_req++;
            chk("hold_dout_valid", 256'(ifc.dout_valid), 256'd1);
            chk("hold_dout_id", 256'(ifc.dout_id), 256'd0);
            chk("hold_dout_hash", ifc.dout_hash, DIG_ABC);
            chk("hold_req_ready", 256'(ifc.req_ready), 256'd0);
            chk("hold_no_start", 256'(n_starts), 256'(s0));
        end
        @(posedge clk);
        #1 ifc.dout_ready = 1'b1;
        wait_done("t5_backpressure");

        // reset while the core is working, then a clean rerun
        exp_gnt.push_back(0);
        s0 = n_starts;
        push_blk(0, BLK_ABC, 1'b1, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = (n_starts != s0);
        end
        if (!seen) note_fail("t6_core_start");
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_dout_valid", 256'(ifc.dout_valid), 256'd0);
        chk("mid_rst_dout_hash", ifc.dout_hash, 256'd0);
        chk("mid_rst_busy", 256'(busy), 256'd0);
        chk("mid_rst_core_hashin", ifc.core_hashin, 256'd0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_rst_no_dout", 256'(ifc.dout_valid), 256'd0);
        exp_gnt.push_back(0); push_dig(0, DIG_ABC);
        push_blk(0, BLK_ABC, 1'b1, 1'b1);
        wait_done("t6_rerun");
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
